simt_pc_stack: RTL
==================

// Module: simt_pc_stack
// PURPOSE
//  Next-generation per-block program counter with branch-divergence support for a
//  THREADS_PER_BLOCK-wide SIMT core. Evaluates per-thread NZP against BRnzp, keeps one
//  shared PC plus an active-thread mask, and serialises divergent paths on a reconvergence
//  stack. Reconvergence happens at explicit SYNC instructions. Sits between decoder/ALU
//  NZP regs and the fetcher.
// PARAMETERS
//  THREADS_PER_BLOCK      4  thread lanes per block (mask width)
//  DATA_MEM_DATA_BITS     8  width of decoded_immediate
//  PROGRAM_MEM_ADDR_BITS  8  PC width
//  STACK_DEPTH            4  reconvergence stack entries (>=1)
// PORTS
//  clk               in   1     clock
//  reset             in   1     synchronous, active-high
//  enable            in   1     block active; all state frozen when low
//  start             in   1     1-cycle pulse: launch block
//  thread_enable     in   T     threads present in block (T=THREADS_PER_BLOCK)
//  core_state        in   3     core FSM state; updates only when == 3'b101 (UPDATE)
//  decoded_pc_mux    in   1     current instr is BRnzp
//  decoded_nzp       in   3     BRnzp condition mask
//  decoded_immediate in   DDB   branch target (low PMAB bits used)
//  decoded_sync      in   1     current instr is SYNC (reconvergence point)
//  decoded_ret       in   1     current instr is RET
//  nzp               in   3*T   per-thread NZP, lane i at [3i+2:3i]
//  current_pc        in   PMAB  PC of instruction in UPDATE
//  next_pc           out  PMAB  registered next PC
//  active_mask       out  T     lanes executing next instruction
//  stack_depth       out  clog2(STACK_DEPTH+1)  valid entries
//  done              out  1     block finished (sticky until start/reset)
//  stack_overflow    out  1     sticky error
// BEHAVIOUR
//  - Reset: next_pc=0, active_mask=0, stack_depth=0, done=0, stack_overflow=0, all entries invalid.
//  - start (enable high, any core_state): next_pc=0, active_mask=thread_enable, stack cleared,
//    done=0, overflow=0. start has priority over UPDATE in same cycle.
//  - All updates below occur in the cycle core_state==3'b101 && enable && !done; results
//    visible next cycle (1-cycle latency). Otherwise all outputs hold.
//  - Entry = {pc, mask, pending}. taken[i] = active_mask[i] & |(nzp[3i+:3] & decoded_nzp).
//  - Priority: decoded_ret > decoded_pc_mux > decoded_sync > default.
//  - Default: next_pc = current_pc+1 (wraps modulo 2^PMAB).
//  - BRnzp, taken==active_mask: next_pc=imm. taken==0: next_pc=current_pc+1.
//  - BRnzp divergent: push {current_pc+1, active_mask&~taken, pending=1};
//    active_mask=taken; next_pc=imm.
//  - Divergent with stack full: no push, stack_overflow=1, active_mask unchanged,
//    next_pc=current_pc+1 (branch suppressed).
//  - SYNC, stack empty: next_pc=current_pc+1.
//  - SYNC, top pending: swap. next_pc=top.pc, active_mask=top.mask;
//    top := {current_pc+1, top.mask|active_mask, pending=0}.
//  - SYNC, top not pending: pop. active_mask=top.mask (union), next_pc=current_pc+1.
//  - RET, stack empty: done=1, active_mask=0, next_pc holds.
//  - RET, top pending: pop. next_pc=top.pc, active_mask=top.mask.
//  - RET, top not pending: pop. next_pc=top.pc, active_mask=top.mask & ~active_mask.
//    If that mask is 0, done=1.
//  - active_mask is never driven with lanes outside thread_enable as latched at start.
//  - reset mid-operation: overrides everything, returns to reset values next cycle.
// TESTING
//  1 T=4, start thread_enable=4'b0111; BR nzp=3'b010 all lanes Z, imm=0x20, pc=5 ->
//    next_pc=0x20, mask=0111, depth=0.
//  2 Divergence: lanes0,1 Z, lane2 P, BRz imm=0x10 at pc=3 -> next_pc=0x10, mask=0011,
//    depth=1. SYNC at pc=0x12 -> next_pc=4, mask=0100. SYNC at 0x12 again -> mask=0111,
//    next_pc=0x13, depth=0.
//  3 STACK_DEPTH=1: nested divergent BR with depth=1 -> overflow=1, next_pc=pc+1,
//    mask unchanged, depth=1.
//  4 RET with empty stack, mask=1111 -> done=1, mask=0. Further UPDATE cycles change nothing.
//    start clears done.
//  5 current_pc=0xFF default instr -> next_pc=0x00. enable=0 during UPDATE -> all outputs hold.
//  6 reset asserted with depth=2 in UPDATE with BR -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/simt_pc_stack_if.sv
// Control/status bundle between the decoder/ALU side and the per-block PC unit.
interface simt_pc_stack_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                             enable;
  logic                             start;
  logic [THREADS_PER_BLOCK-1:0]     thread_enable;
  logic [2:0]                       core_state;
  logic                             decoded_pc_mux;
  logic [2:0]                       decoded_nzp;
  logic [DATA_MEM_DATA_BITS-1:0]    decoded_immediate;
  logic                             decoded_sync;
  logic                             decoded_ret;
  logic [3*THREADS_PER_BLOCK-1:0]   nzp;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc;
  logic [THREADS_PER_BLOCK-1:0]     active_mask;
  logic [DW-1:0]                    stack_depth;
  logic                             done;
  logic                             stack_overflow;

  modport master (
    output enable, start, thread_enable, core_state, decoded_pc_mux, decoded_nzp,
           decoded_immediate, decoded_sync, decoded_ret, nzp, current_pc,
    input  next_pc, active_mask, stack_depth, done, stack_overflow
  );
  modport slave (
    input  enable, start, thread_enable, core_state, decoded_pc_mux, decoded_nzp,
           decoded_immediate, decoded_sync, decoded_ret, nzp, current_pc,
    output next_pc, active_mask, stack_depth, done, stack_overflow
  );
endinterface

// File: rtl/simt_pc_stack.sv
// Shared-PC SIMT branch unit: per-lane NZP evaluation, active mask, and a
// reconvergence stack that serialises divergent paths until SYNC/RET.
module simt_lane_taken (
  input  logic       active,
  input  logic [2:0] nzp,
  input  logic [2:0] cond,
  output logic       taken
);
  assign taken = active & (|(nzp & cond));
endmodule

module simt_pc_stack #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
) (
  input logic           clk,
  input logic           reset,
  simt_pc_stack_if.slave bus
);
  localparam int T  = THREADS_PER_BLOCK;
  localparam int PA = PROGRAM_MEM_ADDR_BITS;
  localparam int SD = STACK_DEPTH;
  localparam int DW = $clog2(SD + 1);
  localparam logic [2:0] ST_UPDATE = 3'b101;

  logic [PA-1:0] pc_q;
  logic [T-1:0]  mask_q, en_mask_q;
  logic [DW-1:0] sp_q;
  logic          done_q, ovf_q;

  logic [SD-1:0][PA-1:0] stk_pc;
  logic [SD-1:0][T-1:0]  stk_mask;
  logic [SD-1:0]         stk_pend;

  logic [T-1:0]  taken;
  logic [PA-1:0] pc_inc, imm, top_pc;
  logic [T-1:0]  top_mask, ret_mask;
  logic          top_pend, upd, empty, full;

  for (genvar i = 0; i < T; i++) begin : g_lane
    simt_lane_taken u_lane (
      .active (mask_q[i]),
      .nzp    (bus.nzp[3*i +: 3]),
      .cond   (bus.decoded_nzp),
      .taken  (taken[i])
    );
  end

  assign pc_inc   = bus.current_pc + PA'(1);
  assign imm      = PA'(bus.decoded_immediate);
  assign upd      = bus.enable && (bus.core_state == ST_UPDATE) && !done_q;
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == DW'(SD));
  assign ret_mask = top_mask & ~mask_q;

  // Top-of-stack entry is at index sp-1; empty stack reads as zeros.
  always_comb begin
    top_pc   = '0;
    top_mask = '0;
    top_pend = 1'b0;
    for (int i = 0; i < SD; i++) begin
      if (DW'(i + 1) == sp_q) begin
        top_pc   = stk_pc[i];
        top_mask = stk_mask[i];
        top_pend = stk_pend[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      mask_q    <= '0;
      en_mask_q <= '0;
      sp_q      <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      stk_pc    <= '0;
      stk_mask  <= '0;
      stk_pend  <= '0;
    end else if (bus.enable && bus.start) begin
      pc_q      <= '0;
      mask_q    <= bus.thread_enable;
      en_mask_q <= bus.thread_enable;
      sp_q      <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (upd) begin
      if (bus.decoded_ret) begin
        if (empty) begin
          done_q <= 1'b1;
          mask_q <= '0;
        end else begin
          sp_q <= sp_q - DW'(1);
          pc_q <= top_pc;
          if (top_pend) begin
            mask_q <= top_mask & en_mask_q;
          end else begin
            mask_q <= ret_mask & en_mask_q;
            if ((ret_mask & en_mask_q) == '0) done_q <= 1'b1;
          end
        end
      end else if (bus.decoded_pc_mux) begin
        if (taken == mask_q) begin
          pc_q <= imm;
        end else if (taken == '0) begin
          pc_q <= pc_inc;
        end else if (full) begin
          // No room to park the not-taken lanes: suppress the branch.
          ovf_q <= 1'b1;
          pc_q  <= pc_inc;
        end else begin
          for (int i = 0; i < SD; i++) begin
            if (DW'(i) == sp_q) begin
              stk_pc[i]   <= pc_inc;
              stk_mask[i] <= mask_q & ~taken;
              stk_pend[i] <= 1'b1;
            end
          end
          sp_q   <= sp_q + DW'(1);
          mask_q <= taken;
          pc_q   <= imm;
        end
      end else if (bus.decoded_sync) begin
        if (empty) begin
          pc_q <= pc_inc;
        end else if (top_pend) begin
          // Run the parked path; the entry now records where everyone rejoins.
          pc_q   <= top_pc;
          mask_q <= top_mask & en_mask_q;
          for (int i = 0; i < SD; i++) begin
            if (DW'(i + 1) == sp_q) begin
              stk_pc[i]   <= pc_inc;
              stk_mask[i] <= top_mask | mask_q;
              stk_pend[i] <= 1'b0;
            end
          end
        end else begin
          mask_q <= top_mask & en_mask_q;
          pc_q   <= pc_inc;
          sp_q   <= sp_q - DW'(1);
        end
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  assign bus.next_pc        = pc_q;
  assign bus.active_mask    = mask_q;
  assign bus.stack_depth    = sp_q;
  assign bus.done           = done_q;
  assign bus.stack_overflow = ovf_q;
endmodule
